// File: rtl/coin_dispenser_if.sv
// Request/stock/status bundle between a dispense controller and its host.
interface coin_dispenser_if;
   logic       req;
   logic [3:0] amount;
   logic       ten_empty;
   logic       five_empty;
   logic       busy;
   logic       eject_ten;
   logic       eject_five;
   logic       done;
   logic       fault;
   logic [3:0] remaining;

   modport master (
      output req, amount, ten_empty, five_empty,
      input  busy, eject_ten, eject_five, done, fault, remaining
   );

   modport slave (
      input  req, amount, ten_empty, five_empty,
      output busy, eject_ten, eject_five, done, fault, remaining
   );
endinterface

// File: rtl/coin_dispenser.sv
// Pays change in tens then fives; each coin costs 1 select + PULSE_CYC + GAP_CYC cycles.
// No backpressure: req is only honoured in IDLE and ignored otherwise.
module coin_dispenser #(
   parameter int PULSE_CYC = 4,
   parameter int GAP_CYC   = 4
) (
   input  logic             clk,
   input  logic             reset,
   coin_dispenser_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_EJECT_TEN,
      S_EJECT_FIVE,
      S_GAP,
      S_DONE,
      S_FAULT
   } state_t;

   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] rem_q, rem_d;
   logic       ej_ten_q, ej_five_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         ej_ten_q  <= 1'b0;
         ej_five_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         ej_ten_q  <= (state_d == S_EJECT_TEN);
         ej_five_q <= (state_d == S_EJECT_FIVE);
      end
   end

   // The shared counter is loaded on entry to each timed state and counts down to 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               rem_d   = bus.amount;
               state_d = (bus.amount == 4'd0) ? S_DONE : S_SELECT;
            end
         end
         S_SELECT: begin
            if (rem_q >= 4'd2 && !bus.ten_empty) begin
               state_d = S_EJECT_TEN;
               cnt_d   = PULSE_LD;
            end else if (rem_q >= 4'd1 && !bus.five_empty) begin
               state_d = S_EJECT_FIVE;
               cnt_d   = PULSE_LD;
            end else if (rem_q == 4'd0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FAULT;
            end
         end
         S_EJECT_TEN: begin
            if (cnt_q == 4'd0) begin
               rem_d   = rem_q - 4'd2;
               state_d = S_GAP;
               cnt_d   = GAP_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_EJECT_FIVE: begin
            if (cnt_q == 4'd0) begin
               rem_d   = rem_q - 4'd1;
               state_d = S_GAP;
               cnt_d   = GAP_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == 4'd0) begin
               state_d = S_SELECT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            rem_d   = '0;
            state_d = S_IDLE;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
   assign bus.eject_ten  = ej_ten_q;
   assign bus.eject_five = ej_five_q;
   assign bus.done       = (state_q == S_DONE);
   assign bus.fault      = (state_q == S_FAULT);
   assign bus.remaining  = rem_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed bench for coin_dispenser at default timing (4-cycle pulse, 4-cycle gap).
module tb_coin_dispenser;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   coin_dispenser_if bus ();

   coin_dispenser #(.PULSE_CYC(4), .GAP_CYC(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Packs {busy, eject_ten, eject_five, done, fault, remaining}
   function automatic logic [8:0] pk(input logic b, input logic t, input logic f,
                                     input logic d, input logic fl, input logic [3:0] r);
      return {b, t, f, d, fl, r};
   endfunction

   task automatic chk(input string tag, input int t, input logic [8:0] exp);
      logic [8:0] obs;
      obs = {bus.busy, bus.eject_ten, bus.eject_five, bus.done, bus.fault, bus.remaining};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s t=%0d observed{busy,ten,five,done,fault,rem}=%b expected=%b",
                tag, t, obs, exp);
      end
   endtask

   task automatic start(input logic [3:0] a);
      bus.req    = 1'b1;
      bus.amount = a;
      @(negedge clk);
      bus.req    = 1'b0;
   endtask

   // N coins paid entirely in fives: coin k pulses at t = 9k+1 .. 9k+4.
   task automatic run_fives(input string tag, input int n);
      for (int t = 0; t <= 9 * n + 2; t++) begin
         logic       b, p, d;
         logic [3:0] r;
         b = (t <= 9 * n + 1);
         p = (t < 9 * n) && ((t % 9) >= 1) && ((t % 9) <= 4);
         d = (t == 9 * n + 1);
         r = (t <= 9 * n) ? 4'(n - (t + 4) / 9) : 4'd0;
         chk(tag, t, pk(b, 1'b0, p, d, 1'b0, r));
         @(negedge clk);
      end
   endtask

   initial begin
      bus.req        = 1'b0;
      bus.amount     = 4'd0;
      bus.ten_empty  = 1'b0;
      bus.five_empty = 1'b0;
      reset          = 1'b1;
      @(negedge clk);

      // req coincident with reset is dropped
      bus.req    = 1'b1;
      bus.amount = 4'd5;
      @(negedge clk);
      reset   = 1'b0;
      bus.req = 1'b0;
      chk("reset_vals", 0, pk(0, 0, 0, 0, 0, 4'd0));
      @(negedge clk);
      chk("req_with_reset", 1, pk(0, 0, 0, 0, 0, 4'd0));

      // amount=3, both stocked: ten, gap, five, gap, select, done
      start(4'd3);
      for (int t = 0; t <= 20; t++) begin
         logic [3:0] r;
         r = (t < 5) ? 4'd3 : (t < 14) ? 4'd1 : 4'd0;
         chk("amt3", t, pk(t <= 19, (t >= 1 && t <= 4), (t >= 10 && t <= 13),
                           t == 19, 1'b0, r));
         @(negedge clk);
      end

      // amount=4, ten hopper empty: four fives
      bus.ten_empty = 1'b1;
      start(4'd4);
      run_fives("amt4_fives", 4);
      bus.ten_empty = 1'b0;

      // amount=3, five hopper empty: one ten then fault with 1 owed
      bus.five_empty = 1'b1;
      start(4'd3);
      for (int t = 0; t <= 12; t++) begin
         chk("amt3_fault", t, pk(t <= 9, (t >= 1 && t <= 4), 1'b0, 1'b0,
                                 t >= 10, (t < 5) ? 4'd3 : 4'd1));
         @(negedge clk);
      end
      bus.req    = 1'b1;
      bus.amount = 4'd5;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         chk("fault_sticky", t, pk(0, 0, 0, 0, 1, 4'd1));
      end
      bus.req        = 1'b0;
      bus.five_empty = 1'b0;
      reset          = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("fault_reset", 0, pk(0, 0, 0, 0, 0, 4'd0));

      // amount=0: one busy cycle carrying done
      start(4'd0);
      chk("amt0_done", 0, pk(1, 0, 0, 1, 0, 4'd0));
      @(negedge clk);
      chk("amt0_idle", 1, pk(0, 0, 0, 0, 0, 4'd0));

      // reset on the 2nd cycle of a ten pulse, then a normal five
      start(4'd2);
      chk("rst_mid_sel", 0, pk(1, 0, 0, 0, 0, 4'd2));
      @(negedge clk);
      chk("rst_mid_p1", 1, pk(1, 1, 0, 0, 0, 4'd2));
      @(negedge clk);
      chk("rst_mid_p2", 2, pk(1, 1, 0, 0, 0, 4'd2));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_after", 3, pk(0, 0, 0, 0, 0, 4'd0));
      start(4'd1);
      run_fives("after_rst_five", 1);

      // amount=2 with req/amount=9 toggled mid-transaction
      start(4'd2);
      for (int t = 0; t <= 11; t++) begin
         chk("req_ignored", t, pk(t <= 10, (t >= 1 && t <= 4), 1'b0, t == 10,
                                  1'b0, (t < 5) ? 4'd2 : 4'd0));
         bus.req    = (t >= 1 && t <= 5) ? ~bus.req : 1'b0;
         bus.amount = 4'd9;
         @(negedge clk);
      end
      bus.req = 1'b0;
      @(negedge clk);
      chk("req_ignored_idle", 12, pk(0, 0, 0, 0, 0, 4'd0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coin_dispenser.md
COIN_DISPENSER -- requirements
Module: coin_dispenser

Interface
REQ-001 Parameter PULSE_CYC, default 4: cycles each eject output is held high per coin (legal 1..15).
REQ-002 Parameter GAP_CYC, default 4: idle cycles after each coin before the next coin selection (legal 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  dispense request; sampled only in IDLE.
REQ-006 amount  input  4  change owed, in 5-unit coins (0..15); sampled with req.
REQ-007 ten_empty  input  1  ten-coin hopper empty; sampled in SELECT.
REQ-008 five_empty  input  1  five-coin hopper empty; sampled in SELECT.
REQ-009 busy  output  1  high in every state except IDLE and FAULT.
REQ-010 eject_ten  output  1  ten-coin solenoid drive, registered.
REQ-011 eject_five  output  1  five-coin solenoid drive, registered.
REQ-012 done  output  1  one-cycle pulse when the request is fully paid.
REQ-013 fault  output  1  sticky; high when owed change cannot be paid from stock.
REQ-014 remaining  output  4  undispensed balance, in 5-unit coins.

Function
REQ-015 States: IDLE, SELECT, EJECT_TEN, EJECT_FIVE, GAP, DONE, FAULT.
REQ-016 IDLE: on req=1, latch amount into remaining; go to DONE if amount=0, else to SELECT.
REQ-017 req in any state other than IDLE is ignored; amount is not re-sampled.
REQ-018 SELECT lasts exactly one cycle and chooses the next step:
- remaining>=2 and ten_empty=0 -> EJECT_TEN.
- Otherwise remaining>=1 and five_empty=0 -> EJECT_FIVE.
- Otherwise remaining=0 -> DONE.
- Otherwise -> FAULT.
REQ-019 Stock inputs are re-evaluated at every SELECT visit; a hopper refilled mid-transaction is used from the next SELECT on.
REQ-020 EJECT_TEN/EJECT_FIVE: the matching eject output is high for exactly PULSE_CYC consecutive cycles; the other eject output stays low.
REQ-021 remaining decrements by 2 (ten) or 1 (five) on the last cycle of the pulse, then the machine enters GAP.
REQ-022 GAP: both eject outputs low for exactly GAP_CYC cycles, then SELECT.
REQ-023 eject_ten and eject_five are never high in the same cycle.
REQ-024 DONE: done=1 for one cycle, remaining=0, then IDLE; a new req is accepted on the cycle after DONE.
REQ-025 FAULT: fault=1, busy=0, eject outputs low, remaining holds the unpaid balance; leaves only on reset.
REQ-026 remaining never underflows; a ten is chosen only when remaining>=2.
REQ-027 One shared down-counter times both PULSE and GAP; it reloads on each state entry.
REQ-028 Timing for amount=N coins from request acceptance to the done pulse: sum over coins of (1 + PULSE_CYC + GAP_CYC), plus 1 SELECT cycle, plus 1 DONE cycle.

Reset
REQ-029 reset=1 at a rising edge forces IDLE and clears the counter.
REQ-030 Values after reset: remaining=0, busy=0, eject_ten=0, eject_five=0, done=0, fault=0.
REQ-031 Reset overrides every state, including mid-pulse and FAULT; eject outputs are low on the cycle after reset is sampled.
REQ-032 A req coincident with reset is discarded.

Verification
REQ-033 Defaults; amount=3, both hoppers stocked -> one ten pulse (4 cycles), a 4-cycle gap, one five pulse (4 cycles), a 4-cycle gap, then done exactly 20 cycles after the first busy cycle; remaining steps 3 -> 1 -> 0.
REQ-034 amount=4, ten_empty=1 -> four eject_five pulses, no eject_ten, then done; remaining steps 4,3,2,1,0.
REQ-035 amount=3, five_empty=1 -> one ten pulse, then fault=1, busy=0, remaining=1, no done; req afterwards is ignored until reset.
REQ-036 amount=0 -> busy for 1 cycle, then done pulse, no eject activity.
REQ-037 reset asserted on the 2nd cycle of a ten pulse -> eject_ten low on the next cycle, all outputs at reset values; a following req with amount=1 dispenses one five normally.
REQ-038 req toggled with amount=9 during an active amount=2 transaction -> ignored; a single ten pulse, then done, remaining=0.
